// File: rtl/dlx_pkg.sv
// Shared DLX decode definitions: opcode/func encodings, control enums and
// the decoded-instruction bundle passed between decode and its pipeline register.
package dlx_pkg;

    // Primary opcodes, instruction bits [31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQZ  = 6'h04;
    localparam logic [5:0] OP_BNEZ  = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SUBI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LHI   = 6'h0F;
    localparam logic [5:0] OP_JR    = 6'h12;
    localparam logic [5:0] OP_JALR  = 6'h13;
    localparam logic [5:0] OP_SLLI  = 6'h14;
    localparam logic [5:0] OP_SRLI  = 6'h16;
    localparam logic [5:0] OP_SRAI  = 6'h17;
    localparam logic [5:0] OP_SEQI  = 6'h18;
    localparam logic [5:0] OP_SNEI  = 6'h19;
    localparam logic [5:0] OP_SLTI  = 6'h1A;
    localparam logic [5:0] OP_SLEI  = 6'h1C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes, instruction bits [5:0]
    localparam logic [5:0] FN_SLL = 6'h04;
    localparam logic [5:0] FN_SRL = 6'h06;
    localparam logic [5:0] FN_SRA = 6'h07;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SEQ = 6'h28;
    localparam logic [5:0] FN_SNE = 6'h29;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_SLE = 6'h2C;

    // Link register written by jal/jalr
    localparam logic [4:0] LINK_REG = 5'd31;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7,
        ALU_SEQ = 4'd8,
        ALU_SNE = 4'd9,
        ALU_SLT = 4'd10,
        ALU_SLE = 4'd11
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'd0,
        PC_BEQZ = 2'd1,
        PC_BNEZ = 2'd2,
        PC_JUMP = 2'd3
    } pc_cmd_t;

    // How the immediate field is turned into the datapath-width operand
    typedef enum logic [2:0] {
        IMM_ZERO   = 3'd0,
        IMM_SEXT16 = 3'd1,
        IMM_ZEXT16 = 3'd2,
        IMM_HI16   = 3'd3,
        IMM_SEXT26 = 3'd4
    } imm_kind_t;

    // Width-independent part of the decoded instruction
    typedef struct packed {
        alu_op_t    alu_op;
        pc_cmd_t    pc_cmd;
        logic       iv_alu;
        logic       pc_alu;
        logic       d_load_enable;
        logic       d_write_enable;
        logic       rd_we;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       illegal;
    } dec_bundle_t;

    // A source operand collides with a pending load destination; r0 never does
    function automatic logic reg_match(input logic used, input logic [4:0] src,
                                       input logic [4:0] dst);
        return used && (src != 5'd0) && (src == dst);
    endfunction

endpackage

// File: rtl/dlx_decoder_pipe_decode.sv
// Purely combinational DLX instruction decode into dec_bundle_t, the extended
// immediate and the source-register use flags needed by hazard detection.
module dlx_decode_comb
    import dlx_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output dec_bundle_t     dec,
    output logic [XLEN-1:0] iv,
    output logic            use_rs1,
    output logic            use_rs2
);

    logic [5:0] opcode;
    logic [5:0] func;
    logic [4:0] f_rs1;
    logic [4:0] f_rs2;
    logic [4:0] f_rd;
    logic       legal;
    imm_kind_t  imm_kind;

    assign opcode = instr[31:26];
    assign f_rs1  = instr[25:21];
    assign f_rs2  = instr[20:16];
    assign f_rd   = instr[15:11];
    assign func   = instr[5:0];

    // Field decode by instruction class; illegal encodings collapse to an inert bundle
    always_comb begin
        dec      = '0;
        imm_kind = IMM_ZERO;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        legal    = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                dec.rs1   = f_rs1;
                dec.rs2   = f_rs2;
                dec.rd    = f_rd;
                dec.rd_we = 1'b1;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                case (func)
                    FN_ADD:  dec.alu_op = ALU_ADD;
                    FN_SUB:  dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_XOR:  dec.alu_op = ALU_XOR;
                    FN_SLL:  dec.alu_op = ALU_SLL;
                    FN_SRL:  dec.alu_op = ALU_SRL;
                    FN_SRA:  dec.alu_op = ALU_SRA;
                    FN_SEQ:  dec.alu_op = ALU_SEQ;
                    FN_SNE:  dec.alu_op = ALU_SNE;
                    FN_SLT:  dec.alu_op = ALU_SLT;
                    FN_SLE:  dec.alu_op = ALU_SLE;
                    default: legal      = 1'b0;
                endcase
            end
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI,
            OP_SRAI, OP_SEQI, OP_SNEI, OP_SLTI, OP_SLEI: begin
                dec.rs1    = f_rs1;
                dec.rd     = f_rs2;
                dec.iv_alu = 1'b1;
                dec.rd_we  = 1'b1;
                use_rs1    = 1'b1;
                // Logical immediates are unsigned masks, everything else is signed
                if ((opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI)) begin
                    imm_kind = IMM_ZEXT16;
                end else begin
                    imm_kind = IMM_SEXT16;
                end
                case (opcode)
                    OP_SUBI: dec.alu_op = ALU_SUB;
                    OP_ANDI: dec.alu_op = ALU_AND;
                    OP_ORI:  dec.alu_op = ALU_OR;
                    OP_XORI: dec.alu_op = ALU_XOR;
                    OP_SLLI: dec.alu_op = ALU_SLL;
                    OP_SRLI: dec.alu_op = ALU_SRL;
                    OP_SRAI: dec.alu_op = ALU_SRA;
                    OP_SEQI: dec.alu_op = ALU_SEQ;
                    OP_SNEI: dec.alu_op = ALU_SNE;
                    OP_SLTI: dec.alu_op = ALU_SLT;
                    OP_SLEI: dec.alu_op = ALU_SLE;
                    default: dec.alu_op = ALU_ADD;
                endcase
            end
            OP_LHI: begin
                // r0 + (imm << 16): no source register is read
                dec.rd     = f_rs2;
                dec.iv_alu = 1'b1;
                dec.rd_we  = 1'b1;
                imm_kind   = IMM_HI16;
            end
            OP_LW: begin
                dec.rs1           = f_rs1;
                dec.rd            = f_rs2;
                dec.iv_alu        = 1'b1;
                dec.rd_we         = 1'b1;
                dec.d_load_enable = 1'b1;
                imm_kind          = IMM_SEXT16;
                use_rs1           = 1'b1;
            end
            OP_SW: begin
                dec.rs1            = f_rs1;
                dec.rs2            = f_rs2;
                dec.iv_alu         = 1'b1;
                dec.d_write_enable = 1'b1;
                imm_kind           = IMM_SEXT16;
                use_rs1            = 1'b1;
                use_rs2            = 1'b1;
            end
            OP_BEQZ, OP_BNEZ: begin
                dec.rs1    = f_rs1;
                dec.pc_alu = 1'b1;
                dec.iv_alu = 1'b1;
                dec.pc_cmd = (opcode == OP_BEQZ) ? PC_BEQZ : PC_BNEZ;
                imm_kind   = IMM_SEXT16;
                use_rs1    = 1'b1;
            end
            OP_J, OP_JAL: begin
                dec.pc_alu = 1'b1;
                dec.iv_alu = 1'b1;
                dec.pc_cmd = PC_JUMP;
                imm_kind   = IMM_SEXT26;
                if (opcode == OP_JAL) begin
                    dec.rd    = LINK_REG;
                    dec.rd_we = 1'b1;
                end else begin
                    dec.rd    = 5'd0;
                    dec.rd_we = 1'b0;
                end
            end
            OP_JR, OP_JALR: begin
                // Target comes from rs1 + 0
                dec.rs1    = f_rs1;
                dec.iv_alu = 1'b1;
                dec.pc_cmd = PC_JUMP;
                use_rs1    = 1'b1;
                if (opcode == OP_JALR) begin
                    dec.rd    = LINK_REG;
                    dec.rd_we = 1'b1;
                end else begin
                    dec.rd    = 5'd0;
                    dec.rd_we = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
            imm_kind    = IMM_ZERO;
            use_rs1     = 1'b0;
            use_rs2     = 1'b0;
        end else begin
            // Writes to r0 are architecturally discarded
            dec.rd_we = dec.rd_we & (dec.rd != 5'd0);
        end
    end

    // Immediate extension to the datapath width
    always_comb begin
        case (imm_kind)
            IMM_SEXT16: iv = XLEN'($signed(instr[15:0]));
            IMM_ZEXT16: iv = XLEN'(instr[15:0]);
            IMM_HI16:   iv = XLEN'({instr[15:0], 16'h0000});
            IMM_SEXT26: iv = XLEN'($signed(instr[25:0]));
            default:    iv = '0;
        endcase
    end

endmodule

// File: rtl/dlx_decoder_pipe.sv
// Registered, handshaked DLX decode stage with flush and load-use stall.
module dlx_decoder_pipe
    import dlx_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [3:0]      alu_op,
    output logic [1:0]      pc_cmd,
    output logic            iv_alu,
    output logic            pc_alu,
    output logic            d_load_enable,
    output logic            d_write_enable,
    output logic            rd_we,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] iv,
    output logic            illegal
);

    dec_bundle_t     dec;
    logic [XLEN-1:0] dec_iv;
    logic            use_rs1;
    logic            use_rs2;

    logic            out_valid_q, out_valid_d;
    dec_bundle_t     bundle_q, bundle_d;
    logic [XLEN-1:0] iv_q, iv_d;
    logic [XLEN-1:0] pc_q, pc_d;
    // Destination of a load that left the stage on the previous cycle
    logic            hz_valid_q, hz_valid_d;
    logic [4:0]      hz_rd_q, hz_rd_d;

    logic            ld_held;
    logic            out_fire;
    logic            stall;
    logic            accept;

    dlx_decode_comb #(
        .XLEN (XLEN)
    ) u_decode (
        .instr   (in_instr),
        .dec     (dec),
        .iv      (dec_iv),
        .use_rs1 (use_rs1),
        .use_rs2 (use_rs2)
    );

    // Load-use detection and the input handshake
    always_comb begin
        ld_held  = out_valid_q & bundle_q.d_load_enable;
        out_fire = out_valid_q & out_ready;
        stall    = HAZARD_EN & in_valid &
                   ((ld_held & (reg_match(use_rs1, dec.rs1, bundle_q.rd) |
                                reg_match(use_rs2, dec.rs2, bundle_q.rd))) |
                    (hz_valid_q & (reg_match(use_rs1, dec.rs1, hz_rd_q) |
                                   reg_match(use_rs2, dec.rs2, hz_rd_q))));
        in_ready = !reset & !stall & !flush & (!out_valid_q | out_ready);
        accept   = in_valid & in_ready;
    end

    // Next-state for the output register and the post-handover hazard window
    always_comb begin
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        iv_d        = iv_q;
        pc_d        = pc_q;
        hz_valid_d  = 1'b0;
        hz_rd_d     = hz_rd_q;
        if (flush) begin
            // Drop the held instruction and forget any pending load
            out_valid_d = 1'b0;
            hz_rd_d     = 5'd0;
        end else begin
            if (out_fire && bundle_q.d_load_enable) begin
                hz_valid_d = HAZARD_EN;
                hz_rd_d    = bundle_q.rd;
            end else begin
                hz_rd_d    = hz_rd_q;
            end
            if (accept) begin
                out_valid_d = 1'b1;
                bundle_d    = dec;
                iv_d        = dec_iv;
                pc_d        = in_pc;
            end else if (out_fire) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
        end
    end

    // Stage registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
            iv_q        <= '0;
            pc_q        <= '0;
            hz_valid_q  <= 1'b0;
            hz_rd_q     <= 5'd0;
        end else begin
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
            iv_q        <= iv_d;
            pc_q        <= pc_d;
            hz_valid_q  <= hz_valid_d;
            hz_rd_q     <= hz_rd_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_pc         = pc_q;
    assign alu_op         = bundle_q.alu_op;
    assign pc_cmd         = bundle_q.pc_cmd;
    assign iv_alu         = bundle_q.iv_alu;
    assign pc_alu         = bundle_q.pc_alu;
    assign d_load_enable  = bundle_q.d_load_enable;
    assign d_write_enable = bundle_q.d_write_enable;
    assign rd_we          = bundle_q.rd_we;
    assign rs1            = bundle_q.rs1;
    assign rs2            = bundle_q.rs2;
    assign rd             = bundle_q.rd;
    assign iv             = iv_q;
    assign illegal        = bundle_q.illegal;

endmodule

// File: tb/tb_dlx_decoder_pipe.sv
// Scoreboard bench for dlx_decoder_pipe: directed test-plan sequences followed
// by randomized traffic, all checked against a table-driven reference decoder.
module tb_dlx_decoder_pipe;

    localparam int XLEN = 32;

    logic            clk;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [3:0]      alu_op;
    logic [1:0]      pc_cmd;
    logic            iv_alu;
    logic            pc_alu;
    logic            d_load_enable;
    logic            d_write_enable;
    logic            rd_we;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] iv;
    logic            illegal;

    typedef struct {
        logic [3:0]  alu;
        logic [1:0]  pcc;
        logic        iv_alu;
        logic        pc_alu;
        logic        ld;
        logic        st;
        logic        we;
        logic        ill;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] iv;
        logic [31:0] pc;
        int          use1;
        int          use2;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: stage occupancy, load held in it, load handed over last cycle
    bit   m_full = 1'b0;
    int   m_held = 0;
    int   m_hz   = 0;
    bit   m_acc  = 1'b0;

    // Function codes / immediate opcodes listed in ALU-op order (index == alu_op)
    int rfn [12] = '{'h20, 'h22, 'h24, 'h25, 'h26, 'h04, 'h06, 'h07, 'h28, 'h29, 'h2A, 'h2C};
    int iop [12] = '{'h08, 'h0A, 'h0C, 'h0D, 'h0E, 'h14, 'h16, 'h17, 'h18, 'h19, 'h1A, 'h1C};
    int ops [22] = '{'h00, 'h02, 'h03, 'h04, 'h05, 'h08, 'h0A, 'h0C, 'h0D, 'h0E, 'h0F,
                     'h12, 'h13, 'h14, 'h16, 'h17, 'h18, 'h19, 'h1A, 'h1C, 'h23, 'h2B};

    dlx_decoder_pipe #(
        .XLEN      (XLEN),
        .HAZARD_EN (1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .in_pc          (in_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .alu_op         (alu_op),
        .pc_cmd         (pc_cmd),
        .iv_alu         (iv_alu),
        .pc_alu         (pc_alu),
        .d_load_enable  (d_load_enable),
        .d_write_enable (d_write_enable),
        .rd_we          (rd_we),
        .rs1            (rs1),
        .rs2            (rs2),
        .rd             (rd),
        .iv             (iv),
        .illegal        (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int find(input int tbl [12], input int key);
        for (int i = 0; i < 12; i++) begin
            if (tbl[i] == key) return i;
        end
        return -1;
    endfunction

    // Reference decoder built from the instruction-set rules
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        int op, fn, a, b, c, k;
        logic [31:0] s16;
        bit legal;
        e = '{default: 0};
        op = int'(w[31:26]);
        a = int'(w[25:21]);
        b = int'(w[20:16]);
        c = int'(w[15:11]);
        fn = int'(w[5:0]);
        s16 = {{16{w[15]}}, w[15:0]};
        legal = 1'b1;
        if (op == 'h00) begin
            k = find(rfn, fn);
            if (k < 0) legal = 1'b0;
            else begin
                e.alu = 4'(k); e.rs1 = 5'(a); e.rs2 = 5'(b); e.rd = 5'(c); e.we = 1'b1;
                e.use1 = a; e.use2 = b;
            end
        end else if (find(iop, op) >= 0) begin
            e.alu = 4'(find(iop, op)); e.rs1 = 5'(a); e.rd = 5'(b); e.iv_alu = 1'b1; e.we = 1'b1;
            e.iv = (op >= 'h0C && op <= 'h0E) ? {16'h0000, w[15:0]} : s16;
            e.use1 = a;
        end else if (op == 'h0F) begin
            e.rd = 5'(b); e.iv = {w[15:0], 16'h0000}; e.iv_alu = 1'b1; e.we = 1'b1;
        end else if (op == 'h23) begin
            e.rs1 = 5'(a); e.rd = 5'(b); e.iv = s16; e.iv_alu = 1'b1; e.ld = 1'b1; e.we = 1'b1;
            e.use1 = a;
        end else if (op == 'h2B) begin
            e.rs1 = 5'(a); e.rs2 = 5'(b); e.iv = s16; e.iv_alu = 1'b1; e.st = 1'b1;
            e.use1 = a; e.use2 = b;
        end else if (op == 'h04 || op == 'h05) begin
            e.rs1 = 5'(a); e.iv = s16; e.pc_alu = 1'b1; e.iv_alu = 1'b1; e.pcc = 2'(op - 3);
            e.use1 = a;
        end else if (op == 'h02 || op == 'h03) begin
            e.iv = {{6{w[25]}}, w[25:0]}; e.pc_alu = 1'b1; e.iv_alu = 1'b1; e.pcc = 2'd3;
            if (op == 'h03) begin e.rd = 5'd31; e.we = 1'b1; end
        end else if (op == 'h12 || op == 'h13) begin
            e.rs1 = 5'(a); e.iv_alu = 1'b1; e.pcc = 2'd3; e.use1 = a;
            if (op == 'h13) begin e.rd = 5'd31; e.we = 1'b1; end
        end else begin
            legal = 1'b0;
        end
        if (!legal) begin
            e = '{default: 0};
            e.ill = 1'b1;
        end
        if (e.rd == 5'd0) e.we = 1'b0;
        e.pc = pc;
        return e;
    endfunction

    function automatic bit hits(input exp_t e, input int r);
        return (r != 0) && (e.use1 == r || e.use2 == r);
    endfunction

    function automatic logic [127:0] pack_exp(input exp_t e);
        return 128'({e.alu, e.pcc, e.iv_alu, e.pc_alu, e.ld, e.st, e.we,
                     e.rs1, e.rs2, e.rd, e.ill, e.iv, e.pc});
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [5:0]  op;
        logic [31:0] w;
        if ($urandom_range(0, 9) == 0) op = 6'($urandom);
        else if ($urandom_range(0, 4) == 0) op = 6'h23;
        else op = 6'(ops[$urandom_range(0, 21)]);
        w = $urandom;
        w[31:26] = op;
        w[25:21] = 5'($urandom_range(0, 3));
        w[20:16] = 5'($urandom_range(0, 3));
        if (op == 6'h00) begin
            w[15:11] = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 9) != 0) w[5:0] = 6'(rfn[$urandom_range(0, 11)]);
        end
        return w;
    endfunction

    // One clock of stimulus; predicts in_ready/out_valid and pushes accepted work
    task automatic step(input logic v, input logic [31:0] ins, input logic ordy,
                        input logic fl, input logic rst);
        exp_t cand;
        bit   exp_rdy, fire, haz;
        int   new_hz;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = $urandom;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        #6;
        cand = ref_decode(in_instr, in_pc);
        haz = v && (hits(cand, m_held) || hits(cand, m_hz));
        exp_rdy = !rst && !fl && (!m_full || ordy) && !haz;
        chk("in_ready", 128'(in_ready), 128'(exp_rdy));
        if (!rst) chk("out_valid", 128'(out_valid), 128'(m_full));
        m_acc = v && exp_rdy;
        fire = m_full && ordy;
        new_hz = fire ? m_held : 0;
        if (rst || fl) begin
            sb.delete();
            m_full = 1'b0;
            m_held = 0;
            m_hz   = 0;
        end else begin
            m_hz = new_hz;
            if (m_acc) begin
                sb.push_back(cand);
                m_full = 1'b1;
                m_held = cand.ld ? int'(cand.rd) : 0;
            end else if (fire) begin
                m_full = 1'b0;
                m_held = 0;
            end
        end
    endtask

    // Presents an instruction until the model predicts acceptance
    task automatic send(input logic [31:0] ins, input logic ordy);
        for (int t = 0; t < 8; t++) begin
            step(1'b1, ins, ordy, 1'b0, 1'b0);
            if (m_acc) return;
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout: instr %h not accepted within 8 cycles", ins);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: compares the presented bundle with the scoreboard head, pops on handover
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", 128'(out_valid), 128'(0));
            end else begin
                chk("bundle", 128'({alu_op, pc_cmd, iv_alu, pc_alu, d_load_enable,
                                    d_write_enable, rd_we, rs1, rs2, rd, illegal, iv, out_pc}),
                    pack_exp(sb[0]));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0;
        in_pc = '0; out_ready = 1'b0;

        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        idle(1);
        chk("reset_outputs", 128'({out_valid, alu_op, pc_cmd, iv_alu, pc_alu, d_load_enable,
                                   d_write_enable, rd_we, rs1, rs2, rd, illegal, iv, out_pc}),
            128'(0));

        // add r3,r1,r2
        send(32'h00221820, 1'b1);
        idle(1);
        // addi / andi back-to-back, sign vs zero extension
        send(32'h2022FFFF, 1'b1);
        send(32'h3022FFFF, 1'b1);
        idle(1);
        // lw r4,8(r1) then dependent add r5,r4,r0
        send(32'h8C240008, 1'b1);
        send(32'h00802820, 1'b1);
        idle(2);
        // jal -4 held by execute for three cycles while fetch keeps offering
        send(32'h0FFFFFFC, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h00221820, 1'b0, 1'b0, 1'b0);
        send(32'h00221820, 1'b1);
        idle(1);
        // illegal opcode, and illegal R-type func
        send(32'hFC000000, 1'b1);
        send(32'h00221821, 1'b1);
        idle(1);
        // flush releases a load-use stall and drops the held load
        send(32'h8C240008, 1'b0);
        step(1'b1, 32'h00802820, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00802820, 1'b0, 1'b1, 1'b0);
        send(32'h00802820, 1'b1);
        idle(1);
        // reset with a valid bundle and a pending stall
        send(32'h8C240008, 1'b0);
        step(1'b1, 32'h00802820, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00802820, 1'b0, 1'b0, 1'b1);
        send(32'h00802820, 1'b1);
        idle(1);
        // lhi, sw, bnez, jalr
        send(32'h3C051234, 1'b1);
        send(32'hAC430010, 1'b1);
        send(32'h1460FFF0, 1'b1);
        send(32'h4C200000, 1'b1);
        idle(2);

        // Randomized traffic with back-pressure, flushes and occasional resets
        for (int n = 0; n < 600; n++) begin
            logic v, ordy, fl, rst;
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 39) == 0);
            rst  = ($urandom_range(0, 149) == 0);
            if (fl) ordy = 1'b0;
            step(v, gen_instr(), ordy, fl, rst);
        end
        idle(4);
        chk("drain", 128'(sb.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
